io_responder: RTL

IO_RESPONDER -- requirements
Module: io_responder

---
 rtl/cpu_io_pkg.sv | 43 ++++
 rtl/io_tx_fifo.sv | 63 ++++++
 rtl/io_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU memory-mapped IO block: address window,
// register offsets, timer states, control/status bit positions.
// Pure declarations; no logic, no latency, no flow control.
package cpu_io_pkg;

    // IO window occupies the top 256 bytes of the address space
    localparam logic [31:0] IO_BASE = 32'hFFFF_FF00;

    // Register byte offsets within the window
    localparam logic [7:0] OFF_CYCLE  = 8'h00;
    localparam logic [7:0] OFF_TCTRL  = 8'h04;
    localparam logic [7:0] OFF_TLOAD  = 8'h08;
    localparam logic [7:0] OFF_TCOUNT = 8'h0C;
    localparam logic [7:0] OFF_TSTAT  = 8'h10;
    localparam logic [7:0] OFF_TXDATA = 8'h14;
    localparam logic [7:0] OFF_TXSTAT = 8'h18;

    // TX FIFO geometry
    localparam int TX_DEPTH = 4;
    localparam int TX_PTR_W = 2;
    localparam int TX_CNT_W = 3;

    // Timer states
    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } tmr_state_t;

    // TCTRL bits
    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_AUTO = 1;
    localparam int TCTRL_IE   = 2;

    // TSTAT bits
    localparam int TSTAT_PEND = 0;

    // TXSTAT bits
    localparam int TXSTAT_FULL   = 0;
    localparam int TXSTAT_EMPTY  = 1;
    localparam int TXSTAT_CNT_LO = 2;
    localparam int TXSTAT_OVF    = 5;

endpackage

// File: rtl/io_tx_fifo.sv
// 4-entry byte FIFO feeding the TX consumer; head is shown combinationally.
// Latency: a pushed byte is visible at head the cycle after the push edge.
// Backpressure: push while full is accepted only if a pop happens the same cycle.
module io_tx_fifo
    import cpu_io_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [7:0]          push_data,
    output logic                full,
    output logic                empty,
    output logic [TX_CNT_W-1:0] count,
    output logic [7:0]          head
);

    logic [7:0]          mem [TX_DEPTH];
    logic [TX_PTR_W-1:0] wr_ptr;
    logic [TX_PTR_W-1:0] rd_ptr;
    logic [TX_CNT_W-1:0] cnt;
    logic                do_pop;
    logic                do_push;

    assign full  = (cnt == TX_CNT_W'(TX_DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    // Empty FIFO shows 0 rather than a stale entry
    assign head  = empty ? 8'h00 : mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the 2-bit width; count tracks occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + TX_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + TX_PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + TX_CNT_W'(1);
                2'b01:   cnt <= cnt - TX_CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped IO responder: cycle counter, down-counting timer with IRQ, TX byte FIFO.
// Latency: reads return registered data one cycle after the request, like Memoria.
// Backpressure: none on the CPU bus; TX FIFO drops pushes when full (sticky OVF).
module io_responder
    import cpu_io_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic        Wr,
    input  logic [31:0] Datain,
    output logic [31:0] Dataout,
    output logic        Sel,
    output logic        Irq,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    logic [7:0]  offset;
    logic        hit;
    logic        rd_hit;
    logic        wr_hit;
    logic        wr_tctrl;
    logic        wr_tload;
    logic        wr_tstat;
    logic        wr_txdata;
    logic        wr_txstat;

    logic [31:0] cycle_cnt;
    logic        tctrl_en;
    logic        tctrl_auto;
    logic        tctrl_ie;
    logic [31:0] tload;
    logic [31:0] tcount;
    logic [31:0] tcount_nxt;
    logic        pend;
    logic        ovf;
    logic        expire;
    tmr_state_t  tstate;
    tmr_state_t  tstate_nxt;

    logic                fifo_full;
    logic                fifo_empty;
    logic [TX_CNT_W-1:0] fifo_count;
    logic                tx_pop;
    logic [31:0]         rd_val;

    // Only word-aligned accesses inside the top 256-byte window are ours
    assign offset = Address[7:0];
    assign hit    = (Address[31:8] == IO_BASE[31:8]) && (Address[1:0] == 2'b00);
    assign rd_hit = hit & ~Wr;
    assign wr_hit = hit & Wr;

    assign wr_tctrl  = wr_hit && (offset == OFF_TCTRL);
    assign wr_tload  = wr_hit && (offset == OFF_TLOAD);
    assign wr_tstat  = wr_hit && (offset == OFF_TSTAT);
    assign wr_txdata = wr_hit && (offset == OFF_TXDATA);
    assign wr_txstat = wr_hit && (offset == OFF_TXSTAT);

    assign Irq      = pend & tctrl_ie;
    assign tx_valid = ~fifo_empty;
    assign tx_pop   = tx_valid & tx_ready;

    io_tx_fifo u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_txdata),
        .pop       (tx_pop),
        .push_data (Datain[7:0]),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (tx_data)
    );

    // Timer next state: countdown/expiry in RUN, then a TCTRL write overrides both
    always_comb begin
        tstate_nxt = tstate;
        tcount_nxt = tcount;
        expire     = 1'b0;
        if (tstate == T_RUN) begin
            if (tcount != 32'd0) begin
                tcount_nxt = tcount - 32'd1;
            end else begin
                expire = 1'b1;
                if (tctrl_auto) begin
                    tcount_nxt = tload;
                end else begin
                    tstate_nxt = T_IDLE;
                end
            end
        end
        if (wr_tctrl) begin
            if (Datain[TCTRL_EN]) begin
                tstate_nxt = T_RUN;
                tcount_nxt = tload;
            end else begin
                tstate_nxt = T_IDLE;
                tcount_nxt = tcount;
            end
        end
    end

    // Timer state and count registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tstate <= T_IDLE;
            tcount <= 32'd0;
        end else begin
            tstate <= tstate_nxt;
            tcount <= tcount_nxt;
        end
    end

    // Software-visible registers; hardware sets of PEND/OVF win over W1C clears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt  <= 32'd0;
            tctrl_en   <= 1'b0;
            tctrl_auto <= 1'b0;
            tctrl_ie   <= 1'b0;
            tload      <= 32'd0;
            pend       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (wr_tctrl) begin
                tctrl_en   <= Datain[TCTRL_EN];
                tctrl_auto <= Datain[TCTRL_AUTO];
                tctrl_ie   <= Datain[TCTRL_IE];
            end else if (expire && !tctrl_auto) begin
                tctrl_en <= 1'b0;
            end
            if (wr_tload) begin
                tload <= Datain;
            end
            if (expire) begin
                pend <= 1'b1;
            end else if (wr_tstat && Datain[TSTAT_PEND]) begin
                pend <= 1'b0;
            end
            if (wr_txdata && fifo_full && !tx_pop) begin
                ovf <= 1'b1;
            end else if (wr_txstat && Datain[TXSTAT_OVF]) begin
                ovf <= 1'b0;
            end
        end
    end

    // Read mux; unmapped offsets return 0
    always_comb begin
        rd_val = 32'd0;
        case (offset)
            OFF_CYCLE:  rd_val = cycle_cnt;
            OFF_TCTRL: begin
                rd_val[TCTRL_EN]   = tctrl_en;
                rd_val[TCTRL_AUTO] = tctrl_auto;
                rd_val[TCTRL_IE]   = tctrl_ie;
            end
            OFF_TLOAD:  rd_val = tload;
            OFF_TCOUNT: rd_val = tcount;
            OFF_TSTAT:  rd_val[TSTAT_PEND] = pend;
            OFF_TXDATA: rd_val[TX_CNT_W-1:0] = fifo_count;
            OFF_TXSTAT: begin
                rd_val[TXSTAT_FULL]                    = fifo_full;
                rd_val[TXSTAT_EMPTY]                   = fifo_empty;
                rd_val[TXSTAT_CNT_LO +: TX_CNT_W]      = fifo_count;
                rd_val[TXSTAT_OVF]                     = ovf;
            end
            default:    rd_val = 32'd0;
        endcase
    end

    // Registered read return; writes and misses drive 0 with Sel low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Dataout <= 32'd0;
            Sel     <= 1'b0;
        end else begin
            Dataout <= rd_hit ? rd_val : 32'd0;
            Sel     <= rd_hit;
        end
    end

endmodule
